nios2_ocimem_arbiter: RTL and testbench

Sysclk-domain controller that shares the single-port on-chip debug memory (OCI RAM) between two requesters: the JTAG debug-slave command path (jdo plus take_action strobes) and the CPU's Avalon debug_mem_slave.
It holds the JTAG monitor address and data registers (MonAReg/MonDReg), auto-increments the address on JTAG accesses, and reports completion through monitor_ready.
It sits between the debug-slave wrapper's sysclk outputs and the OCI RAM instance.

---
 rtl/nios2_ocimem_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_nios2_ocimem_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/nios2_ocimem_arbiter.sv
// Shares the single-port OCI debug RAM between the JTAG monitor command path
// (MonAReg/MonDReg with auto-increment) and the CPU's Avalon debug_mem_slave.
module nios2_ocimem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [DATA_W-1:0] avs_writedata,
    output logic [DATA_W-1:0] avs_readdata,
    output logic              avs_waitrequest,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [ADDR_W-1:0] MonAReg,
    output logic [DATA_W-1:0] MonDReg,
    output logic              monitor_ready,
    output logic              jtag_overrun,
    output logic [2:0]        fsm_state
);

    // Avalon handshake: the master raises avs_read or avs_write and holds
    // address/data stable while avs_waitrequest is 1; the transfer completes
    // in the single cycle where avs_waitrequest is 0 (read data valid then).

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        J_WR    = 3'd1,
        J_RD    = 3'd2,
        J_RDATA = 3'd3,
        A_WR    = 3'd4,
        A_RD    = 3'd5,
        A_RDATA = 3'd6
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state;
    state_t            state_next;
    logic              jpend;
    logic              jop_wr;
    logic              last_grant_jtag;
    logic [ADDR_W-1:0] addr_q;
    logic              avs_req;
    logic              contend;
    logic              grant_jtag;
    logic              jtag_done;
    logic              unused_jdo;

    assign fsm_state  = state;
    assign avs_req    = avs_read | avs_write;
    assign contend    = jpend & avs_req;
    // On a tie the requester that did not win the previous tie goes first.
    assign grant_jtag = jpend & (~avs_req | ~last_grant_jtag);
    assign jtag_done  = (state == J_WR) || (state == J_RDATA);
    assign unused_jdo = ^jdo;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (grant_jtag) begin
                    state_next = jop_wr ? J_WR : J_RD;
                end else if (avs_req) begin
                    state_next = avs_write ? A_WR : A_RD;
                end
            end
            J_WR:    state_next = IDLE;
            J_RD:    state_next = J_RDATA;
            J_RDATA: state_next = IDLE;
            A_WR:    state_next = IDLE;
            A_RD:    state_next = A_RDATA;
            A_RDATA: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        ram_addr        = addr_q;
        ram_wdata       = '0;
        ram_we          = 1'b0;
        avs_waitrequest = 1'b1;
        avs_readdata    = '0;
        case (state)
            J_WR: begin
                ram_addr  = MonAReg;
                ram_wdata = MonDReg;
                ram_we    = 1'b1;
            end
            J_RD: begin
                ram_addr = MonAReg;
            end
            A_WR: begin
                ram_addr        = avs_address;
                ram_wdata       = avs_writedata;
                ram_we          = 1'b1;
                avs_waitrequest = 1'b0;
            end
            A_RD: begin
                ram_addr = avs_address;
            end
            A_RDATA: begin
                avs_readdata    = ram_rdata;
                avs_waitrequest = 1'b0;
            end
            default: begin
            end
        endcase
    end

    // ram_addr keeps its last driven value while no access is in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q <= '0;
        end else begin
            addr_q <= ram_addr;
        end
    end

    // Only contended grants move the round-robin pointer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant_jtag <= 1'b0;
        end else if (state == IDLE && contend) begin
            last_grant_jtag <= grant_jtag;
        end
    end

    // jpend is still 1 on the completion edge, so a strobe landing there
    // counts as an overrun and cannot collide with the completion updates.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            MonAReg       <= '0;
            MonDReg       <= '0;
            jpend         <= 1'b0;
            jop_wr        <= 1'b0;
            monitor_ready <= 1'b0;
            jtag_overrun  <= 1'b0;
        end else begin
            if (jtag_done) begin
                MonAReg       <= MonAReg + ADDR_ONE;
                jpend         <= 1'b0;
                monitor_ready <= 1'b1;
                if (state == J_RDATA) begin
                    MonDReg <= ram_rdata;
                end
            end
            if (take_action_ocimem_b) begin
                if (jpend) begin
                    jtag_overrun <= 1'b1;
                end else begin
                    MonDReg       <= jdo[DATA_W-1:0];
                    jpend         <= 1'b1;
                    jop_wr        <= 1'b1;
                    monitor_ready <= 1'b0;
                end
            end else if (take_action_ocimem_a) begin
                if (jpend) begin
                    jtag_overrun <= 1'b1;
                end else begin
                    MonAReg       <= jdo[ADDR_W+1:2];
                    jpend         <= jdo[37];
                    jop_wr        <= 1'b0;
                    monitor_ready <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_nios2_ocimem_arbiter.sv
// Directed bench for nios2_ocimem_arbiter: a behavioural 1-cycle RAM model
// plus cycle-exact checks of the JTAG and Avalon paths and their arbitration.
module tb_nios2_ocimem_arbiter;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [37:0]       jdo;
    logic              take_a;
    logic              take_b;
    logic [ADDR_W-1:0] avs_address;
    logic              avs_read;
    logic              avs_write;
    logic [DATA_W-1:0] avs_writedata;
    logic [DATA_W-1:0] avs_readdata;
    logic              avs_waitrequest;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_we;
    logic [DATA_W-1:0] ram_rdata;
    logic [ADDR_W-1:0] mon_a;
    logic [DATA_W-1:0] mon_d;
    logic              monitor_ready;
    logic              jtag_overrun;
    logic [2:0]        fsm_state;

    logic              bd_we;
    logic [ADDR_W-1:0] bd_addr;
    logic [DATA_W-1:0] bd_data;
    logic [DATA_W-1:0] mem [256];

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [2:0] S_IDLE = 3'd0, S_J_WR = 3'd1, S_J_RD = 3'd2,
        S_J_RDATA = 3'd3, S_A_WR = 3'd4, S_A_RD = 3'd5, S_A_RDATA = 3'd6;

    always #5 clk = ~clk;

    nios2_ocimem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .jdo                  (jdo),
        .take_action_ocimem_a (take_a),
        .take_action_ocimem_b (take_b),
        .avs_address          (avs_address),
        .avs_read             (avs_read),
        .avs_write            (avs_write),
        .avs_writedata        (avs_writedata),
        .avs_readdata         (avs_readdata),
        .avs_waitrequest      (avs_waitrequest),
        .ram_addr             (ram_addr),
        .ram_wdata            (ram_wdata),
        .ram_we               (ram_we),
        .ram_rdata            (ram_rdata),
        .MonAReg              (mon_a),
        .MonDReg              (mon_d),
        .monitor_ready        (monitor_ready),
        .jtag_overrun         (jtag_overrun),
        .fsm_state            (fsm_state)
    );

    // Synchronous single-port RAM with a backdoor preload port.
    always @(posedge clk) begin
        if (bd_we) mem[bd_addr] <= bd_data;
        else if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic jtag_a(input logic [7:0] addr, input logic rd);
        jdo = '0;
        jdo[37] = rd;
        jdo[9:2] = addr;
        take_a = 1'b1;
        @(negedge clk);
        take_a = 1'b0;
        jdo = '0;
    endtask

    task automatic jtag_b(input logic [31:0] data);
        jdo = {6'b0, data};
        take_b = 1'b1;
        @(negedge clk);
        take_b = 1'b0;
        jdo = '0;
    endtask

    task automatic backdoor(input logic [7:0] addr, input logic [31:0] data);
        bd_addr = addr;
        bd_data = data;
        bd_we = 1'b1;
        @(negedge clk);
        bd_we = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0;
        bd_we = 1'b0; bd_addr = '0; bd_data = '0;
        // Requests driven while reset is held must be ignored.
        jdo = {6'b0, 32'h0000FFFF}; take_a = 1'b0; take_b = 1'b1;
        avs_address = 8'h07; avs_read = 1'b1; avs_write = 1'b0; avs_writedata = '0;
        repeat (3) @(negedge clk);
        check("rst_waitreq", 64'(avs_waitrequest), 64'h1);
        check("rst_ram_we", 64'(ram_we), 64'h0);
        check("rst_mon_a", 64'(mon_a), 64'h0);
        check("rst_ready", 64'(monitor_ready), 64'h0);
        check("rst_state", 64'(fsm_state), 64'(S_IDLE));
        take_b = 1'b0; jdo = '0; avs_read = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_state", 64'(fsm_state), 64'(S_IDLE));
        check("post_rst_waitreq", 64'(avs_waitrequest), 64'h1);

        // JTAG write burst from 0x10
        jtag_a(8'h10, 1'b0);
        check("burst_mon_a_load", 64'(mon_a), 64'h10);
        for (int i = 0; i < 3; i++) begin
            jtag_b(32'hA0 + i);
            check("burst_ready_clr", 64'(monitor_ready), 64'h0);
            @(negedge clk);
            check("burst_state", 64'(fsm_state), 64'(S_J_WR));
            check("burst_we", 64'(ram_we), 64'h1);
            check("burst_addr", 64'(ram_addr), 64'(32'h10 + i));
            check("burst_wdata", 64'(ram_wdata), 64'(32'hA0 + i));
            @(negedge clk);
            check("burst_ready", 64'(monitor_ready), 64'h1);
            check("burst_mon_a_inc", 64'(mon_a), 64'(32'h11 + i));
        end
        for (int i = 0; i < 3; i++) check("burst_mem", 64'(mem[8'h10 + i]), 64'(32'hA0 + i));

        // JTAG read with address wrap
        backdoor(8'hFF, 32'hDEADBEEF);
        backdoor(8'h00, 32'h00000001);
        jtag_a(8'hFF, 1'b1);
        @(negedge clk);
        check("rd_state_jrd", 64'(fsm_state), 64'(S_J_RD));
        check("rd_addr", 64'(ram_addr), 64'hFF);
        @(negedge clk);
        check("rd_state_jrdata", 64'(fsm_state), 64'(S_J_RDATA));
        check("rd_ready_low", 64'(monitor_ready), 64'h0);
        @(negedge clk);
        check("rd_ready", 64'(monitor_ready), 64'h1);
        check("rd_mon_d_ff", 64'(mon_d), 64'hDEADBEEF);
        check("rd_mon_a_wrap", 64'(mon_a), 64'h00);
        jtag_a(8'h00, 1'b1);
        repeat (3) @(negedge clk);
        check("rd_mon_d_00", 64'(mon_d), 64'h1);
        check("rd_mon_a_01", 64'(mon_a), 64'h01);

        // Contention 1: first tie goes to JTAG
        jtag_b(32'hB0);
        avs_read = 1'b1; avs_address = 8'h10;
        @(negedge clk);
        check("c1_state", 64'(fsm_state), 64'(S_J_WR));
        check("c1_addr", 64'(ram_addr), 64'h01);
        check("c1_waitreq_j", 64'(avs_waitrequest), 64'h1);
        @(negedge clk);
        check("c1_ready", 64'(monitor_ready), 64'h1);
        check("c1_waitreq_idle", 64'(avs_waitrequest), 64'h1);
        @(negedge clk);
        check("c1_state_ard", 64'(fsm_state), 64'(S_A_RD));
        check("c1_waitreq_ard", 64'(avs_waitrequest), 64'h1);
        @(negedge clk);
        check("c1_waitreq_done", 64'(avs_waitrequest), 64'h0);
        check("c1_readdata", 64'(avs_readdata), 64'hA0);
        avs_read = 1'b0;
        @(negedge clk);
        check("c1_back_idle", 64'(fsm_state), 64'(S_IDLE));

        // Contention 2: next tie goes to Avalon
        jtag_b(32'hC0);
        avs_write = 1'b1; avs_address = 8'h20; avs_writedata = 32'h5555AAAA;
        @(negedge clk);
        check("c2_state", 64'(fsm_state), 64'(S_A_WR));
        check("c2_waitreq", 64'(avs_waitrequest), 64'h0);
        check("c2_addr", 64'(ram_addr), 64'h20);
        check("c2_wdata", 64'(ram_wdata), 64'h5555AAAA);
        avs_write = 1'b0;
        @(negedge clk);
        check("c2_ready_pending", 64'(monitor_ready), 64'h0);
        @(negedge clk);
        check("c2_state_jwr", 64'(fsm_state), 64'(S_J_WR));
        check("c2_jaddr", 64'(ram_addr), 64'h02);
        check("c2_jwdata", 64'(ram_wdata), 64'hC0);
        @(negedge clk);
        check("c2_ready", 64'(monitor_ready), 64'h1);
        check("c2_mon_a", 64'(mon_a), 64'h03);
        check("c2_mem_avs", 64'(mem[8'h20]), 64'h5555AAAA);
        check("c2_mem_jtag", 64'(mem[8'h02]), 64'hC0);

        // Overrun: second write strobe while the first is pending
        jtag_b(32'hD0);
        check("ovr_clear_before", 64'(jtag_overrun), 64'h0);
        jtag_b(32'hD1);
        check("ovr_set", 64'(jtag_overrun), 64'h1);
        check("ovr_state", 64'(fsm_state), 64'(S_J_WR));
        check("ovr_wdata", 64'(ram_wdata), 64'hD0);
        @(negedge clk);
        check("ovr_ready", 64'(monitor_ready), 64'h1);
        check("ovr_mon_d", 64'(mon_d), 64'hD0);
        check("ovr_mon_a", 64'(mon_a), 64'h04);
        repeat (3) @(negedge clk);
        check("ovr_idle", 64'(fsm_state), 64'(S_IDLE));
        check("ovr_mon_a_hold", 64'(mon_a), 64'h04);
        check("ovr_mem", 64'(mem[8'h03]), 64'hD0);

        // Avalon write then read at 0x05
        avs_write = 1'b1; avs_address = 8'h05; avs_writedata = 32'h12345678;
        @(negedge clk);
        check("aw_state", 64'(fsm_state), 64'(S_A_WR));
        check("aw_waitreq", 64'(avs_waitrequest), 64'h0);
        check("aw_we", 64'(ram_we), 64'h1);
        avs_write = 1'b0;
        @(negedge clk);
        check("aw_back_idle", 64'(fsm_state), 64'(S_IDLE));
        avs_read = 1'b1;
        @(negedge clk);
        check("ar_waitreq_1", 64'(avs_waitrequest), 64'h1);
        @(negedge clk);
        check("ar_waitreq_2", 64'(avs_waitrequest), 64'h0);
        check("ar_readdata", 64'(avs_readdata), 64'h12345678);
        check("ar_we", 64'(ram_we), 64'h0);
        avs_read = 1'b0;
        @(negedge clk);

        // Read and write together: write wins
        avs_read = 1'b1; avs_write = 1'b1; avs_address = 8'h06; avs_writedata = 32'h0F0F0F0F;
        @(negedge clk);
        check("rw_state", 64'(fsm_state), 64'(S_A_WR));
        check("rw_we", 64'(ram_we), 64'h1);
        avs_read = 1'b0; avs_write = 1'b0;
        repeat (2) @(negedge clk);
        check("rw_mem", 64'(mem[8'h06]), 64'h0F0F0F0F);
        check("ovr_sticky", 64'(jtag_overrun), 64'h1);

        // Reset in the middle of a JTAG write abandons it
        backdoor(8'h30, 32'h11111111);
        jtag_a(8'h30, 1'b0);
        jtag_b(32'h99);
        @(negedge clk);
        check("mid_state", 64'(fsm_state), 64'(S_J_WR));
        reset_n = 1'b0;
        #1;
        check("mid_we", 64'(ram_we), 64'h0);
        check("mid_state_rst", 64'(fsm_state), 64'(S_IDLE));
        check("mid_mon_a", 64'(mon_a), 64'h0);
        check("mid_overrun", 64'(jtag_overrun), 64'h0);
        check("mid_waitreq", 64'(avs_waitrequest), 64'h1);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        check("mid_mem_kept", 64'(mem[8'h30]), 64'h11111111);
        check("mid_ready", 64'(monitor_ready), 64'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
